// File: rtl/packet_timer_if.sv
// Control and strobe bundle between a packet controller (master) and packet_timer (slave).
interface packet_timer_if #(
  parameter int CLK_W = 8,
  parameter int BIT_W = 4
);
  logic             enable_timer;
  logic             abort;
  logic [CLK_W-1:0] clks_per_bit;
  logic [BIT_W-1:0] bits_per_packet;
  logic             half_offset;
  logic             shift_strobe;
  logic             packet_done;
  logic             busy;
  logic [BIT_W-1:0] bit_index;

  modport master (
    output enable_timer, abort, clks_per_bit, bits_per_packet, half_offset,
    input  shift_strobe, packet_done, busy, bit_index
  );

  modport slave (
    input  enable_timer, abort, clks_per_bit, bits_per_packet, half_offset,
    output shift_strobe, packet_done, busy, bit_index
  );
endinterface

// File: rtl/packet_timer.sv
// Bit-period timer: issues one shift_strobe per bit period for a packet of
// bits_per_packet bits, optionally delaying the first strobe by half a period.
module packet_timer #(
  parameter int CLK_W = 8,
  parameter int BIT_W = 4
) (
  input  logic           clk,
  input  logic           s_rst,
  packet_timer_if.slave  tif
);

  localparam int CNT_W = CLK_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] first_target;
  logic [BIT_W-1:0] num_bits;
  logic [CNT_W-1:0] cnt;
  logic             strobe;
  logic             done;
  logic             busy_q;
  logic [BIT_W-1:0] idx;

  logic [CNT_W-1:0] eff_period;
  logic [CNT_W-1:0] eff_first;
  logic [BIT_W-1:0] eff_bits;
  logic             start;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] target;
  logic             fire;
  logic             last_strobe;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    eff_period  = '0;
    eff_first   = '0;
    eff_bits    = '0;
    start       = 1'b0;
    elapsed     = '0;
    target      = '0;
    fire        = 1'b0;
    last_strobe = 1'b0;

    eff_period = (tif.clks_per_bit == '0) ? CNT_W'(1) : {1'b0, tif.clks_per_bit};
    eff_first  = tif.half_offset ? (eff_period + (eff_period >> 1)) : eff_period;
    eff_bits   = (tif.bits_per_packet == '0) ? BIT_W'(1) : tif.bits_per_packet;
    start      = tif.enable_timer && (state != COUNT);

    // Elapsed cycles since the reference point (start cycle or last strobe cycle).
    elapsed = strobe ? '0 : (cnt + CNT_W'(1));
    target  = ((idx == '0) && !strobe) ? first_target : period;
    fire    = ((elapsed + CNT_W'(1)) == target);

    last_strobe = strobe && (idx == (num_bits - BIT_W'(1)));
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (s_rst || tif.abort) begin
      state  <= IDLE;
      cnt    <= '0;
      strobe <= 1'b0;
      done   <= 1'b0;
      busy_q <= 1'b0;
      idx    <= '0;
    end else if (start) begin
      // NOTE: latched configuration is datapath only; it is always reloaded here, so reset leaves it alone.
      period       <= eff_period;
      first_target <= eff_first;
      num_bits     <= eff_bits;
      state        <= COUNT;
      cnt          <= '0;
      idx          <= '0;
      busy_q       <= 1'b1;
      done         <= 1'b0;
      strobe       <= (eff_first == CNT_W'(1));
    end else begin
      case (state)
        IDLE: begin
          cnt    <= '0;
          strobe <= 1'b0;
          done   <= 1'b0;
          busy_q <= 1'b0;
          idx    <= '0;
        end
        COUNT: begin
          if (last_strobe) begin
            state  <= DONE;
            cnt    <= '0;
            strobe <= 1'b0;
            done   <= 1'b1;
            busy_q <= 1'b0;
            idx    <= num_bits;
          end else begin
            cnt    <= elapsed;
            strobe <= fire;
            if (strobe && (idx != num_bits)) begin
              idx <= idx + BIT_W'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          cnt    <= '0;
          strobe <= 1'b0;
          done   <= 1'b0;
          busy_q <= 1'b0;
          idx    <= '0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          strobe <= 1'b0;
          done   <= 1'b0;
          busy_q <= 1'b0;
          idx    <= '0;
        end
      endcase
    end
  end

  assign tif.shift_strobe = strobe;
  assign tif.packet_done  = done;
  assign tif.busy         = busy_q;
  assign tif.bit_index    = idx;

endmodule

// File: tb/tb_packet_timer.sv
// Scoreboard bench for packet_timer: directed packets push expected strobe/done
// events; a negedge monitor pops and compares them as the DUT emits them.
module tb_packet_timer;

  localparam int CLK_W = 8;
  localparam int BIT_W = 4;

  logic clk = 1'b0;
  logic s_rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    bit is_done;
    int at;
    int idx;
  } ev_t;

  ev_t sb[$];

  packet_timer_if #(.CLK_W(CLK_W), .BIT_W(BIT_W)) tif ();

  packet_timer #(.CLK_W(CLK_W), .BIT_W(BIT_W)) dut (
    .clk   (clk),
    .s_rst (s_rst),
    .tif   (tif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Advance to a point #1 after the rising edge that begins cycle c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected strobes at t0+first+per*k (bit_index k), optional done at t0+done_off.
  task automatic push_pkt(input int t0, input int first, input int per, input int n, input int done_off);
    for (int k = 0; k < n; k++) begin
      sb.push_back('{is_done: 1'b0, at: t0 + first + per * k, idx: k});
    end
    if (done_off > 0) sb.push_back('{is_done: 1'b1, at: t0 + done_off, idx: n});
  endtask

  task automatic start_pkt(input int t0, input int p, input int b, input logic h);
    goto(t0);
    tif.clks_per_bit    = CLK_W'(p);
    tif.bits_per_packet = BIT_W'(b);
    tif.half_offset     = h;
    tif.enable_timer    = 1'b1;
    goto(t0 + 1);
    tif.enable_timer    = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, tif.busy, 0);
    check({name, "_strobe"}, tif.shift_strobe, 0);
    check({name, "_done"}, tif.packet_done, 0);
    check({name, "_idx"}, tif.bit_index, 0);
  endtask

  always @(negedge clk) begin
    if (tif.shift_strobe === 1'b1 || tif.packet_done === 1'b1) begin
      check("strobe_done_exclusive", tif.shift_strobe & tif.packet_done, 0);
      if (sb.size() == 0) begin
        check("unexpected_event", {tif.packet_done, tif.shift_strobe}, 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("event_cycle", cyc, e.at);
        check("event_is_done", tif.packet_done, e.is_done);
        check("event_bit_index", tif.bit_index, e.idx);
        if (e.is_done) check("done_busy", tif.busy, 0);
        else           check("strobe_busy", tif.busy, 1);
      end
    end
  end

  initial begin
    s_rst               = 1'b1;
    tif.enable_timer    = 1'b1;
    tif.abort           = 1'b0;
    tif.clks_per_bit    = CLK_W'(5);
    tif.bits_per_packet = BIT_W'(3);
    tif.half_offset     = 1'b0;

    // Reset overrides a held start request.
    goto(3);
    check_idle("reset");
    s_rst            = 1'b0;
    tif.enable_timer = 1'b0;
    goto(5);
    check_idle("post_reset");

    // P=10, 9 bits, no half offset; config inputs disturbed mid-packet.
    push_pkt(10, 10, 10, 9, 91);
    start_pkt(10, 10, 9, 1'b0);
    check("p10_busy_c1", tif.busy, 1);
    check("p10_idx_c1", tif.bit_index, 0);
    goto(15);
    tif.clks_per_bit    = CLK_W'(3);
    tif.bits_per_packet = BIT_W'(2);
    tif.half_offset     = 1'b1;
    goto(100);
    check("p10_busy_c90", tif.busy, 1);
    goto(101);
    check("p10_busy_c91", tif.busy, 0);
    check("p10_idx_c91", tif.bit_index, 9);
    goto(102);
    check_idle("p10_after_done");

    // P=16, 8 bits, half offset: first strobe at 24.
    push_pkt(110, 24, 16, 8, 137);
    start_pkt(110, 16, 8, 1'b1);

    // Zero configuration treated as 1/1.
    push_pkt(260, 1, 1, 1, 2);
    start_pkt(260, 0, 0, 1'b0);
    goto(261);
    check("zero_busy_c1", tif.busy, 1);
    goto(263);
    check_idle("zero_after_done");

    // Abort at cycle 45, ignored restart request at cycle 30.
    push_pkt(270, 10, 10, 4, 0);
    start_pkt(270, 10, 9, 1'b0);
    goto(300);
    tif.enable_timer = 1'b1;
    goto(301);
    tif.enable_timer = 1'b0;
    goto(315);
    tif.abort = 1'b1;
    goto(316);
    tif.abort = 1'b0;
    check_idle("abort45");

    // Abort together with start, in the cycle a strobe becomes due.
    push_pkt(340, 10, 10, 4, 0);
    start_pkt(340, 10, 9, 1'b0);
    goto(389);
    tif.abort        = 1'b1;
    tif.enable_timer = 1'b1;
    goto(390);
    tif.abort        = 1'b0;
    tif.enable_timer = 1'b0;
    check_idle("abort49");
    goto(391);
    check("abort49_busy_next", tif.busy, 0);

    // Start held through DONE restarts immediately.
    push_pkt(400, 4, 4, 2, 9);
    push_pkt(409, 4, 4, 2, 9);
    goto(400);
    tif.clks_per_bit    = CLK_W'(4);
    tif.bits_per_packet = BIT_W'(2);
    tif.half_offset     = 1'b0;
    tif.enable_timer    = 1'b1;
    goto(410);
    tif.enable_timer    = 1'b0;
    check("restart_busy", tif.busy, 1);
    check("restart_idx", tif.bit_index, 0);

    // Synchronous reset mid-packet with start asserted.
    push_pkt(430, 10, 10, 2, 0);
    start_pkt(430, 10, 9, 1'b0);
    goto(455);
    s_rst            = 1'b1;
    tif.enable_timer = 1'b1;
    goto(456);
    s_rst            = 1'b0;
    tif.enable_timer = 1'b0;
    check_idle("mid_reset");
    goto(457);
    check_idle("mid_reset_next");

    goto(480);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
